// File: rtl/bp_fifo_mem_ctrl.sv
// FIFO controller for an external storage array: it holds the pointers, the occupancy,
// and a sticky protocol-error flag. Data bypasses the controller except for the write path.
module bp_fifo_mem_ctrl #(
  parameter int width_p = 97,
  parameter int els_p   = 2,
  localparam int ptr_w  = $clog2(els_p),
  localparam int cnt_w  = $clog2(els_p) + 1
) (
  input  logic               clk_i,
  input  logic               reset_i,

  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,

  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i,

  output logic               mem_w_v_o,
  output logic [ptr_w-1:0]   mem_w_addr_o,
  output logic [width_p-1:0] mem_w_data_o,
  output logic               mem_r_v_o,
  output logic [ptr_w-1:0]   mem_r_addr_o,
  input  logic [width_p-1:0] mem_r_data_i,

  output logic [cnt_w-1:0]   count_o,
  output logic               err_o
);

  localparam logic [cnt_w-1:0] full_cnt = cnt_w'(els_p);

  logic [ptr_w-1:0] wptr;
  logic [ptr_w-1:0] rptr;
  logic [cnt_w-1:0] cnt;
  logic             err_r;
  logic             enq;
  logic             deq;

  // A full FIFO refuses writes even when the head is leaving this cycle, so the write
  // address never coincides with the read address (they match only when empty or full).
  assign ready_o = ~reset_i & (cnt != full_cnt);
  assign v_o     = (cnt != '0);
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  assign mem_w_v_o    = enq;
  assign mem_w_addr_o = wptr;
  assign mem_w_data_o = data_i;
  assign mem_r_v_o    = v_o;
  assign mem_r_addr_o = rptr;
  assign data_o       = mem_r_data_i;

  assign count_o = cnt;
  assign err_o   = err_r;

  // NOTE: the storage array is deliberately not cleared on reset; zeroing cnt makes every
  // stale entry invisible until it has been overwritten by a fresh enqueue.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      err_r <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values,
      // so the pointer, count and flag updates are order-independent.
      // els_p is a power of two, so plain increment wraps els_p-1 -> 0.
      if (enq) wptr <= wptr + 1'b1;
      if (deq) rptr <= rptr + 1'b1;
      case ({enq, deq})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (yumi_i & ~v_o) err_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bp_fifo_mem_ctrl.sv
// Bench for bp_fifo_mem_ctrl: a 2-entry and a 4-entry instance share stimulus, each
// with its own storage array model and a queue-based reference model.
module tb_bp_fifo_mem_ctrl;

  localparam int W = 97;

  logic         clk = 1'b0;
  logic         rst;
  logic         v_i;
  logic         yumi_i;
  logic [W-1:0] data_i;

  // els_p = 2 instance
  logic         a_ready, a_v, a_wv, a_rv, a_err;
  logic [W-1:0] a_data, a_wdata, a_rdata;
  logic [0:0]   a_waddr, a_raddr;
  logic [1:0]   a_count;
  logic [W-1:0] mem_a [2];

  // els_p = 4 instance
  logic         b_ready, b_v, b_wv, b_rv, b_err;
  logic [W-1:0] b_data, b_wdata, b_rdata;
  logic [1:0]   b_waddr, b_raddr;
  logic [2:0]   b_count;
  logic [W-1:0] mem_b [4];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  bp_fifo_mem_ctrl #(.width_p(W), .els_p(2)) dut_a (
    .clk_i(clk), .reset_i(rst),
    .v_i(v_i), .data_i(data_i), .ready_o(a_ready),
    .v_o(a_v), .data_o(a_data), .yumi_i(yumi_i),
    .mem_w_v_o(a_wv), .mem_w_addr_o(a_waddr), .mem_w_data_o(a_wdata),
    .mem_r_v_o(a_rv), .mem_r_addr_o(a_raddr), .mem_r_data_i(a_rdata),
    .count_o(a_count), .err_o(a_err)
  );

  bp_fifo_mem_ctrl #(.width_p(W), .els_p(4)) dut_b (
    .clk_i(clk), .reset_i(rst),
    .v_i(v_i), .data_i(data_i), .ready_o(b_ready),
    .v_o(b_v), .data_o(b_data), .yumi_i(yumi_i),
    .mem_w_v_o(b_wv), .mem_w_addr_o(b_waddr), .mem_w_data_o(b_wdata),
    .mem_r_v_o(b_rv), .mem_r_addr_o(b_raddr), .mem_r_data_i(b_rdata),
    .count_o(b_count), .err_o(b_err)
  );

  // Storage arrays: synchronous write, combinational read, never reset.
  assign a_rdata = mem_a[a_raddr];
  assign b_rdata = mem_b[b_raddr];
  always @(posedge clk) begin
    if (a_wv) mem_a[a_waddr] <= a_wdata;
    if (b_wv) mem_b[b_waddr] <= b_wdata;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         v;
    logic         y;
    logic [W-1:0] d;
    logic         rdy;
    logic         vo;
    logic [1:0]   cnt;
    logic         chk_d;
    logic [W-1:0] dout;
    logic         wv;
  } vec_t;

  vec_t tbl[$];

  task automatic put(input logic v, input logic y, input logic [W-1:0] d, input logic rdy,
                     input logic vo, input logic [1:0] cnt, input logic chk_d,
                     input logic [W-1:0] dout, input logic wv);
    vec_t e;
    e.v = v; e.y = y; e.d = d; e.rdy = rdy; e.vo = vo; e.cnt = cnt;
    e.chk_d = chk_d; e.dout = dout; e.wv = wv;
    tbl.push_back(e);
  endtask

  // Per-cycle comparison of one instance against its queue model (sz entries, capacity n).
  task automatic rchk(input string t, input int n, input int sz, input logic [W-1:0] head,
                      input logic em, input logic rdy, input logic vo, input logic [3:0] cnt,
                      input logic [W-1:0] d, input logic er, input logic wv, input logic rv,
                      input logic [3:0] wa, input logic [3:0] ra);
    check({t, " ready"}, rdy, sz != n);
    check({t, " v_o"}, vo, sz != 0);
    check({t, " count"}, cnt, sz);
    if (sz != 0) check({t, " order"}, d, head);
    check({t, " err"}, er, em);
    check({t, " w_v"}, wv, v_i && (sz != n));
    check({t, " r_v"}, rv, sz != 0);
    check({t, " addr_conflict"}, wv && rv && (wa == ra), 1'b0);
  endtask

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  logic         err_a, err_b;

  initial begin
    // Reset state, with active inputs that must be ignored.
    rst = 1'b1; v_i = 1'b1; yumi_i = 1'b1; data_i = '0;
    #2;
    check("rst ready", a_ready, 1'b0);
    check("rst v_o", a_v, 1'b0);
    check("rst count", a_count, 2'd0);
    check("rst err", a_err, 1'b0);
    check("rst mem_w_v", a_wv, 1'b0);
    check("rst mem_r_v", a_rv, 1'b0);
    tick; tick;
    v_i = 1'b0; yumi_i = 1'b0; rst = 1'b0;
    #1;
    check("post-rst ready", a_ready, 1'b1);
    check("post-rst v_o", a_v, 1'b0);

    // Fill/drain, then full with simultaneous enqueue and dequeue.
    put(1'b1, 1'b0, 97'h1, 1'b1, 1'b0, 2'd0, 1'b0, 97'h0, 1'b1);
    put(1'b1, 1'b0, 97'h2, 1'b1, 1'b1, 2'd1, 1'b1, 97'h1, 1'b1);
    put(1'b1, 1'b0, 97'h3, 1'b0, 1'b1, 2'd2, 1'b1, 97'h1, 1'b0);
    put(1'b0, 1'b1, 97'h0, 1'b0, 1'b1, 2'd2, 1'b1, 97'h1, 1'b0);
    put(1'b0, 1'b1, 97'h0, 1'b1, 1'b1, 2'd1, 1'b1, 97'h2, 1'b0);
    put(1'b0, 1'b0, 97'h0, 1'b1, 1'b0, 2'd0, 1'b0, 97'h0, 1'b0);
    put(1'b1, 1'b0, 97'hA, 1'b1, 1'b0, 2'd0, 1'b0, 97'h0, 1'b1);
    put(1'b1, 1'b0, 97'hB, 1'b1, 1'b1, 2'd1, 1'b1, 97'hA, 1'b1);
    put(1'b1, 1'b1, 97'hC, 1'b0, 1'b1, 2'd2, 1'b1, 97'hA, 1'b0);
    put(1'b1, 1'b0, 97'hC, 1'b1, 1'b1, 2'd1, 1'b1, 97'hB, 1'b1);
    put(1'b0, 1'b1, 97'h0, 1'b0, 1'b1, 2'd2, 1'b1, 97'hB, 1'b0);
    put(1'b0, 1'b1, 97'h0, 1'b1, 1'b1, 2'd1, 1'b1, 97'hC, 1'b0);
    put(1'b0, 1'b0, 97'h0, 1'b1, 1'b0, 2'd0, 1'b0, 97'h0, 1'b0);
    #1;
    foreach (tbl[i]) begin
      v_i = tbl[i].v; yumi_i = tbl[i].y; data_i = tbl[i].d;
      #1;
      check($sformatf("vec%0d ready", i), a_ready, tbl[i].rdy);
      check($sformatf("vec%0d v_o", i), a_v, tbl[i].vo);
      check($sformatf("vec%0d count", i), a_count, tbl[i].cnt);
      if (tbl[i].chk_d) check($sformatf("vec%0d data_o", i), a_data, tbl[i].dout);
      check($sformatf("vec%0d mem_w_v", i), a_wv, tbl[i].wv);
      check($sformatf("vec%0d err", i), a_err, 1'b0);
      tick;
    end

    // Steady streaming: one word in flight, pointers wrap repeatedly.
    v_i = 1'b1; yumi_i = 1'b0; data_i = 97'd0;
    tick;
    for (int i = 0; i < 10; i++) begin
      v_i = 1'b1; yumi_i = 1'b1; data_i = W'(i + 1);
      #1;
      check($sformatf("stream%0d count", i), a_count, 2'd1);
      check($sformatf("stream%0d data_o", i), a_data, W'(i));
      check($sformatf("stream%0d w_v", i), a_wv, 1'b1);
      check($sformatf("stream%0d addr_conflict", i), a_wv && a_rv && (a_waddr == a_raddr), 1'b0);
      tick;
    end
    v_i = 1'b0; yumi_i = 1'b1;
    #1;
    check("stream tail data_o", a_data, 97'd10);
    tick;
    yumi_i = 1'b0;
    #1;
    check("stream drained count", a_count, 2'd0);
    check("stream drained v_o", a_v, 1'b0);

    // Protocol error: yumi while empty is sticky and leaves the count alone.
    yumi_i = 1'b1;
    #1;
    check("err before edge", a_err, 1'b0);
    tick;
    yumi_i = 1'b0;
    #1;
    check("err set", a_err, 1'b1);
    check("err count", a_count, 2'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check($sformatf("err held%0d", i), a_err, 1'b1);
    end

    // Reset mid-operation with a full FIFO.
    v_i = 1'b1; data_i = 97'hAA;
    tick;
    data_i = 97'hBB;
    tick;
    v_i = 1'b0;
    #1;
    check("pre-rst count", a_count, 2'd2);
    #2;
    rst = 1'b1;
    #1;
    check("mid-rst v_o", a_v, 1'b0);
    check("mid-rst ready", a_ready, 1'b0);
    check("mid-rst count", a_count, 2'd0);
    check("mid-rst err", a_err, 1'b0);
    tick;
    #2;
    rst = 1'b0;
    #1;
    check("rel ready", a_ready, 1'b1);
    check("rel v_o", a_v, 1'b0);
    v_i = 1'b1; data_i = 97'hCC;
    tick;
    v_i = 1'b0;
    #1;
    check("fresh v_o", a_v, 1'b1);
    check("fresh data_o", a_data, 97'hCC);

    // Random traffic on both instances against queue models.
    #2; rst = 1'b1; #1; rst = 1'b0;
    qa.delete(); qb.delete(); err_a = 1'b0; err_b = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      logic ea, da, eb, db;
      v_i = 1'($urandom_range(0, 1));
      yumi_i = 1'($urandom_range(0, 99) < 45);
      data_i = W'({$urandom(), $urandom(), $urandom(), $urandom()});
      #1;
      rchk("rnd2", 2, qa.size(), (qa.size() != 0) ? qa[0] : '0, err_a, a_ready, a_v,
           4'(a_count), a_data, a_err, a_wv, a_rv, 4'(a_waddr), 4'(a_raddr));
      rchk("rnd4", 4, qb.size(), (qb.size() != 0) ? qb[0] : '0, err_b, b_ready, b_v,
           4'(b_count), b_data, b_err, b_wv, b_rv, 4'(b_waddr), 4'(b_raddr));
      ea = v_i && (qa.size() != 2); da = yumi_i && (qa.size() != 0);
      eb = v_i && (qb.size() != 4); db = yumi_i && (qb.size() != 0);
      if (yumi_i && qa.size() == 0) err_a = 1'b1;
      if (yumi_i && qb.size() == 0) err_b = 1'b1;
      if (da) void'(qa.pop_front());
      if (ea) qa.push_back(data_i);
      if (db) void'(qb.pop_front());
      if (eb) qb.push_back(data_i);
      tick;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
